// File: rtl/dm_arbiter.sv
// -----------------------------------------------------------------------------
// dm_arbiter
//
// This module shares one single-port data memory between a CPU memory stage
// and a DMA engine. In IDLE it picks one requester and latches that
// requester's command. ISSUE drives the memory for one cycle. READ_WAIT
// collects the read data. The CPU wins contested cycles, except when it has
// won STARVE_MAX contested arbitrations in a row. In that case the DMA is
// granted once.
//
// Latency from req in IDLE:
//   write -> done 1 cycle later (in ISSUE)
//   read  -> done 2 cycles later (in READ_WAIT)
//
// Ports
//   clk, rst               clock, asynchronous active-high reset
//   cpu_req/web/addr/wdata CPU request. web is active-low, 4'b1111 = read
//   cpu_rdata, cpu_done    CPU read data (valid with done), completion pulse
//   cpu_stall              CPU pipeline stall (req pending, not done)
//   dma_req/web/addr/wdata DMA request, same semantics as the CPU port
//   dma_rdata, dma_done    DMA read data, completion pulse
//   dm_cs, dm_web          data-memory chip select, active-low byte enables
//   dm_addr, dm_di         data-memory word address, write data
//   dm_do                  data-memory read data, one cycle after a read issue
// -----------------------------------------------------------------------------
module dm_arbiter #(
    parameter int ADDR_W     = 14,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              cpu_req,
    input  logic [3:0]        cpu_web,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_done,
    output logic              cpu_stall,

    input  logic              dma_req,
    input  logic [3:0]        dma_web,
    input  logic [31:0]       dma_addr,
    input  logic [31:0]       dma_wdata,
    output logic [31:0]       dma_rdata,
    output logic              dma_done,

    output logic              dm_cs,
    output logic [3:0]        dm_web,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_di,
    input  logic [31:0]       dm_do
);

    // The counter must be able to hold STARVE_MAX itself.
    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
    localparam logic [3:0]       WEB_READ   = 4'b1111;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        READ_WAIT = 2'd2
    } state_t;

    state_t            state_r;
    logic              winner_r;      // 1'b0 = CPU, 1'b1 = DMA
    logic [3:0]        web_r;
    logic [ADDR_W-1:0] addr_r;
    logic [31:0]       wdata_r;
    logic [CNT_W-1:0]  starve_r;
    logic              cpu_done_r;
    logic              dma_done_r;
    logic              dm_cs_r;
    logic [3:0]        dm_web_r;
    logic [31:0]       cpu_rdata_r;
    logic [31:0]       dma_rdata_r;

    logic              any_req_s;
    logic              contested_s;
    logic              grant_dma_s;
    logic [3:0]        sel_web_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [31:0]       sel_wdata_s;
    logic              sel_is_write_s;

    // Byte-offset and high address bits are not part of the word address.
    logic              unused_addr_bits_s;
    assign unused_addr_bits_s = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0],
                                  dma_addr[31:ADDR_W+2], dma_addr[1:0]};

    // Arbitration: a sole requester wins, and the CPU wins a contest unless the DMA is starved.
    always_comb begin
        any_req_s   = cpu_req | dma_req;
        contested_s = cpu_req & dma_req;
        grant_dma_s = 1'b0;
        if (contested_s) begin
            grant_dma_s = (starve_r == STARVE_LIM);
        end else if (dma_req) begin
            grant_dma_s = 1'b1;
        end else begin
            grant_dma_s = 1'b0;
        end
    end

    // Command mux feeding the latch registers from the granted port.
    always_comb begin
        sel_web_s   = cpu_web;
        sel_addr_s  = cpu_addr[ADDR_W+1:2];
        sel_wdata_s = cpu_wdata;
        if (grant_dma_s) begin
            sel_web_s   = dma_web;
            sel_addr_s  = dma_addr[ADDR_W+1:2];
            sel_wdata_s = dma_wdata;
        end else begin
            sel_web_s   = cpu_web;
            sel_addr_s  = cpu_addr[ADDR_W+1:2];
            sel_wdata_s = cpu_wdata;
        end
        sel_is_write_s = (sel_web_s != WEB_READ);
    end

    // Main FSM. Memory-side strobes and done pulses are registered on entry to the cycle that shows them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            winner_r    <= 1'b0;
            web_r       <= WEB_READ;
            addr_r      <= {ADDR_W{1'b0}};
            wdata_r     <= 32'h0000_0000;
            starve_r    <= {CNT_W{1'b0}};
            cpu_done_r  <= 1'b0;
            dma_done_r  <= 1'b0;
            dm_cs_r     <= 1'b0;
            dm_web_r    <= WEB_READ;
            cpu_rdata_r <= 32'h0000_0000;
            dma_rdata_r <= 32'h0000_0000;
        end else begin
            // Pulses and strobes last one cycle unless re-armed below.
            cpu_done_r <= 1'b0;
            dma_done_r <= 1'b0;
            dm_cs_r    <= 1'b0;
            dm_web_r   <= WEB_READ;

            case (state_r)
                IDLE: begin
                    if (any_req_s) begin
                        winner_r <= grant_dma_s;
                        web_r    <= sel_web_s;
                        addr_r   <= sel_addr_s;
                        wdata_r  <= sel_wdata_s;
                        dm_cs_r  <= 1'b1;
                        dm_web_r <= sel_web_s;
                        state_r  <= ISSUE;
                        // A write completes in the ISSUE cycle itself.
                        if (sel_is_write_s) begin
                            cpu_done_r <= ~grant_dma_s;
                            dma_done_r <= grant_dma_s;
                        end else begin
                            cpu_done_r <= 1'b0;
                            dma_done_r <= 1'b0;
                        end
                        // Starvation tracking counts only contested CPU wins.
                        if (grant_dma_s) begin
                            starve_r <= {CNT_W{1'b0}};
                        end else if (contested_s && (starve_r != STARVE_LIM)) begin
                            starve_r <= starve_r + CNT_W'(1);
                        end else begin
                            starve_r <= starve_r;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end

                ISSUE: begin
                    if (web_r == WEB_READ) begin
                        // The read completes next cycle, when dm_do is valid.
                        cpu_done_r <= ~winner_r;
                        dma_done_r <= winner_r;
                        state_r    <= READ_WAIT;
                    end else begin
                        state_r    <= IDLE;
                    end
                end

                READ_WAIT: begin
                    if (winner_r) begin
                        dma_rdata_r <= dm_do;
                    end else begin
                        cpu_rdata_r <= dm_do;
                    end
                    state_r <= IDLE;
                end

                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // In the completing read cycle, rdata bypasses the holding register so the value arrives with done.
    always_comb begin
        cpu_rdata = cpu_rdata_r;
        dma_rdata = dma_rdata_r;
        if (state_r == READ_WAIT) begin
            if (winner_r) begin
                dma_rdata = dm_do;
            end else begin
                cpu_rdata = dm_do;
            end
        end else begin
            cpu_rdata = cpu_rdata_r;
            dma_rdata = dma_rdata_r;
        end
    end

    assign cpu_done  = cpu_done_r;
    assign dma_done  = dma_done_r;
    assign cpu_stall = cpu_req & ~cpu_done_r;
    assign dm_cs     = dm_cs_r;
    assign dm_web    = dm_web_r;
    assign dm_addr   = addr_r;
    assign dm_di     = wdata_r;

endmodule

// File: tb/tb_dm_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dm_arbiter
//
// Scoreboard testbench for dm_arbiter. Each driven request pushes an expected
// memory issue (address, byte enables, data) and an expected completion (port,
// cycle, read data). A negedge monitor pops and compares these records when
// the DUT shows dm_cs or a done pulse. A small byte-enabled memory model
// answers reads.
// -----------------------------------------------------------------------------
module tb_dm_arbiter;

    localparam int ADDR_W = 14;

    logic              clk;
    logic              rst;
    logic              cpu_req;
    logic [3:0]        cpu_web;
    logic [31:0]       cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [31:0]       cpu_rdata;
    logic              cpu_done;
    logic              cpu_stall;
    logic              dma_req;
    logic [3:0]        dma_web;
    logic [31:0]       dma_addr;
    logic [31:0]       dma_wdata;
    logic [31:0]       dma_rdata;
    logic              dma_done;
    logic              dm_cs;
    logic [3:0]        dm_web;
    logic [ADDR_W-1:0] dm_addr;
    logic [31:0]       dm_di;
    logic [31:0]       dm_do;

    dm_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_web   (cpu_web),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_done  (cpu_done),
        .cpu_stall (cpu_stall),
        .dma_req   (dma_req),
        .dma_web   (dma_web),
        .dma_addr  (dma_addr),
        .dma_wdata (dma_wdata),
        .dma_rdata (dma_rdata),
        .dma_done  (dma_done),
        .dm_cs     (dm_cs),
        .dm_web    (dm_web),
        .dm_addr   (dm_addr),
        .dm_di     (dm_di),
        .dm_do     (dm_do)
    );

    typedef struct {
        logic [3:0]        web;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } iss_t;

    typedef struct {
        logic        port;     // 0 = CPU, 1 = DMA
        logic        rd;
        logic [31:0] rdata;
        int          cyc;
    } done_t;

    iss_t  iss_q[$];
    done_t done_q[$];
    iss_t  ie;
    done_t de;

    int n_vec;
    int n_err;
    int cyc;
    logic [31:0] mem [0:255];

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter used for latency checks.
    always @(posedge clk) cyc <= cyc + 1;

    // Byte-enabled synchronous memory model with one-cycle read latency.
    always @(posedge clk) begin
        if (dm_cs) begin
            if (dm_web == 4'b1111) begin
                dm_do <= mem[dm_addr[7:0]];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (!dm_web[b]) mem[dm_addr[7:0]][b*8 +: 8] <= dm_di[b*8 +: 8];
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (dm_cs) begin
            if (iss_q.size() == 0) begin
                check("spurious_issue", 32'd1, 32'd0);
            end else begin
                ie = iss_q.pop_front();
                check("dm_addr", 32'(dm_addr), 32'(ie.addr));
                check("dm_web", 32'(dm_web), 32'(ie.web));
                check("dm_di", dm_di, ie.data);
            end
        end else begin
            check("dm_web_idle", 32'(dm_web), 32'hF);
        end
        if (cpu_done || dma_done) begin
            if (done_q.size() == 0) begin
                check("spurious_done", {30'd0, cpu_done, dma_done}, 32'd0);
            end else begin
                de = done_q.pop_front();
                check("done_port", {30'd0, cpu_done, dma_done}, de.port ? 32'd1 : 32'd2);
                check("done_cyc", 32'(cyc), 32'(de.cyc));
                if (de.rd) check("rdata", de.port ? dma_rdata : cpu_rdata, de.rdata);
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Single-port transfer: drive, push expectations, wait for done, release req.
    task automatic xfer(input logic port, input logic [3:0] web, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_rd);
        logic rd;
        bit   seen;
        rd   = (web == 4'b1111);
        seen = 1'b0;
        @(posedge clk); #1;
        if (port) begin
            dma_req = 1'b1; dma_web = web; dma_addr = addr; dma_wdata = wd;
        end else begin
            cpu_req = 1'b1; cpu_web = web; cpu_addr = addr; cpu_wdata = wd;
        end
        iss_q.push_back('{web: web, addr: addr[ADDR_W+1:2], data: wd});
        done_q.push_back('{port: port, rd: rd, rdata: exp_rd, cyc: cyc + (rd ? 2 : 1)});
        for (int k = 0; k < 8 && !seen; k++) begin
            @(negedge clk);
            seen = port ? dma_done : cpu_done;
        end
        if (!seen) check("done_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        cpu_req = 1'b0;
        dma_req = 1'b0;
    endtask

    // Watchdog: stops the run if it wanders off.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int ndone;
        bit dma_turn;
        n_vec = 0; n_err = 0; cyc = 0;
        dm_do = 32'h0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        rst = 1'b1;
        cpu_req = 1'b0; cpu_web = 4'hF; cpu_addr = 32'h0; cpu_wdata = 32'h0;
        dma_req = 1'b0; dma_web = 4'hF; dma_addr = 32'h0; dma_wdata = 32'h0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_cpu_done", 32'(cpu_done), 32'd0);
        check("rst_dma_done", 32'(dma_done), 32'd0);
        check("rst_dm_cs", 32'(dm_cs), 32'd0);
        check("rst_dm_web", 32'(dm_web), 32'hF);
        check("rst_dm_addr", 32'(dm_addr), 32'd0);
        check("rst_cpu_rdata", cpu_rdata, 32'd0);
        check("rst_dma_rdata", dma_rdata, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // CPU full write, then read back and hold.
        xfer(1'b0, 4'b0000, 32'h10, 32'hDEADBEEF, 32'h0);
        xfer(1'b0, 4'b1111, 32'h10, 32'h0, 32'hDEADBEEF);
        repeat (2) @(negedge clk);
        check("cpu_rdata_hold", cpu_rdata, 32'hDEADBEEF);

        // CPU byte write: byte enables pass through and neither rdata changes.
        xfer(1'b0, 4'b1101, 32'h10, 32'h0000AA00, 32'h0);
        @(negedge clk);
        check("dma_rdata_untouched", dma_rdata, 32'd0);
        check("cpu_rdata_after_wr", cpu_rdata, 32'hDEADBEEF);

        // DMA write/read, then a CPU read of the merged word.
        xfer(1'b1, 4'b0000, 32'h40, 32'h12345678, 32'h0);
        xfer(1'b1, 4'b1111, 32'h40, 32'h0, 32'h12345678);
        xfer(1'b0, 4'b1111, 32'h10, 32'h0, 32'hDEADAAEF);
        @(negedge clk);
        check("dma_rdata_hold", dma_rdata, 32'h12345678);

        // DMA upper-half partial write.
        xfer(1'b1, 4'b0011, 32'h10, 32'h55660000, 32'h0);

        // Contested writes: four CPU grants, then one DMA grant, repeated.
        do_reset();
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_web = 4'b0000; cpu_addr = 32'h20; cpu_wdata = 32'hC0C0C0C0;
        dma_req = 1'b1; dma_web = 4'b0000; dma_addr = 32'h24; dma_wdata = 32'hD0D0D0D0;
        n0 = cyc;
        for (int k = 0; k < 10; k++) begin
            dma_turn = ((k % 5) == 4);
            iss_q.push_back('{web: 4'b0000, addr: dma_turn ? 14'd9 : 14'd8,
                              data: dma_turn ? 32'hD0D0D0D0 : 32'hC0C0C0C0});
            done_q.push_back('{port: dma_turn, rd: 1'b0, rdata: 32'h0, cyc: n0 + 1 + 2 * k});
        end
        ndone = 0;
        for (int k = 0; k < 40 && ndone < 10; k++) begin
            @(negedge clk);
            if (cpu_done || dma_done) ndone++;
        end
        check("contest_dones", 32'(ndone), 32'd10);
        @(posedge clk); #1;
        cpu_req = 1'b0; dma_req = 1'b0;

        // Reset during a DMA READ_WAIT aborts the read.
        @(posedge clk); #1;
        dma_req = 1'b1; dma_web = 4'b1111; dma_addr = 32'h40; dma_wdata = 32'h0;
        iss_q.push_back('{web: 4'b1111, addr: 14'd16, data: 32'h0});
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        dma_req = 1'b0;
        @(negedge clk);
        check("abort_dma_done", 32'(dma_done), 32'd0);
        check("abort_dma_rdata", dma_rdata, 32'd0);
        check("abort_dm_cs", 32'(dm_cs), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        xfer(1'b1, 4'b1111, 32'h40, 32'h0, 32'h12345678);

        // CPU holds req over three back-to-back reads; stall drops only on done cycles.
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_web = 4'b1111; cpu_addr = 32'h10; cpu_wdata = 32'h0;
        n0 = cyc;
        for (int k = 0; k < 3; k++) begin
            iss_q.push_back('{web: 4'b1111, addr: 14'd4, data: 32'h0});
            done_q.push_back('{port: 1'b0, rd: 1'b1, rdata: 32'h5566AAEF, cyc: n0 + 2 + 3 * k});
        end
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            check("cpu_stall", 32'(cpu_stall),
                  (k == 2 || k == 5 || k == 8) ? 32'd0 : 32'd1);
        end
        @(posedge clk); #1;
        cpu_req = 1'b0;
        repeat (3) @(negedge clk);

        check("iss_q_empty", 32'(iss_q.size()), 32'd0);
        check("done_q_empty", 32'(done_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
